// File: rtl/csr_exc_sequencer.sv
// -----------------------------------------------------------------------------
// csr_exc_sequencer
//
// Purpose:
//   Trap commit sequencer at the MEM stage of the dual-issue pipe (slot A is
//   older than slot B). Each cycle it picks at most one trap event in priority
//   order: interrupt, slot A exception, slot B exception, ERTN. It then issues
//   the one-cycle CSR write and flush commands. After any flush it ignores all
//   inputs for DRAIN_CYC unstalled cycles while the front end refills.
//
// Handshake:
//   There is no valid/ready pair. An event is accepted on a rising clk edge
//   when the FSM is IDLE, stall=0, and the decoded event is non-null. Command
//   pulses are high for exactly the one cycle after that edge. Data outputs
//   keep their values until the next accepted event.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   stall                      freezes the FSM, the drain counter and input sampling
//   a_valid/b_valid            slot A/B holds a live instruction
//   a_pc/b_pc                  slot A/B PC
//   ecode_a/b, ecode_we_a/b    per-slot exception code and raise flag
//   badv_a/b, badv_we_a/b      per-slot bad virtual address and its valid flag
//   ertn_b                     ERTN in slot B
//   int_pending, crmd_ie       masked interrupt pending, global interrupt enable
//   eentry, era_cur            trap entry vector, current ERA (return target)
//   ecode_out/ecode_we         committed ecode and its write pulse
//   badv_out/badv_we           committed bad address and its write pulse
//   era_out/era_we             trapping PC and its write pulse
//   store_state/restore_state  CRMD->PRMD save pulse / PRMD->CRMD restore pulse
//   flush/flush_pc             pipe flush pulse and redirect target
//   busy                       high whenever the FSM is not IDLE (state debug view)
// -----------------------------------------------------------------------------
module csr_exc_sequencer #(
    parameter int unsigned DRAIN_CYC = 3,
    parameter logic [6:0]  INT_ECODE = 7'h00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        a_valid,
    input  logic        b_valid,
    input  logic [31:0] a_pc,
    input  logic [31:0] b_pc,
    input  logic [6:0]  ecode_a,
    input  logic [6:0]  ecode_b,
    input  logic        ecode_we_a,
    input  logic        ecode_we_b,
    input  logic [31:0] badv_a,
    input  logic [31:0] badv_b,
    input  logic        badv_we_a,
    input  logic        badv_we_b,
    input  logic        ertn_b,
    input  logic        int_pending,
    input  logic        crmd_ie,
    input  logic [31:0] eentry,
    input  logic [31:0] era_cur,
    output logic [6:0]  ecode_out,
    output logic        ecode_we,
    output logic [31:0] badv_out,
    output logic        badv_we,
    output logic [31:0] era_out,
    output logic        era_we,
    output logic        store_state,
    output logic        restore_state,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        busy
);

    typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYC - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [6:0]  r_ecode_out;
    logic        r_ecode_we;
    logic [31:0] r_badv_out;
    logic        r_badv_we;
    logic [31:0] r_era_out;
    logic        r_era_we;
    logic        r_store_state;
    logic        r_restore_state;
    logic        r_flush;
    logic [31:0] r_flush_pc;
    logic        r_busy;

    // Event decode. A raise flag counts only when its slot is valid.
    // ERTN loses to an exception raised in the same slot.
    logic w_int, w_exc_a, w_exc_b, w_ertn, w_evt;
    assign w_int   = int_pending & crmd_ie & (a_valid | b_valid);
    assign w_exc_a = a_valid & ecode_we_a;
    assign w_exc_b = b_valid & ecode_we_b;
    assign w_ertn  = b_valid & ertn_b & ~ecode_we_b;
    assign w_evt   = w_int | w_exc_a | w_exc_b | w_ertn;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state         <= S_IDLE;
            r_cnt           <= 4'd0;
            r_ecode_out     <= 7'd0;
            r_ecode_we      <= 1'b0;
            r_badv_out      <= 32'd0;
            r_badv_we       <= 1'b0;
            r_era_out       <= 32'd0;
            r_era_we        <= 1'b0;
            r_store_state   <= 1'b0;
            r_restore_state <= 1'b0;
            r_flush         <= 1'b0;
            r_flush_pc      <= 32'd0;
            r_busy          <= 1'b0;
        end else begin
            // Pulses drop every cycle, stalled or not, unless re-armed below.
            r_ecode_we      <= 1'b0;
            r_badv_we       <= 1'b0;
            r_era_we        <= 1'b0;
            r_store_state   <= 1'b0;
            r_restore_state <= 1'b0;
            r_flush         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!stall && w_evt) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= CNT_INIT;
                        r_busy  <= 1'b1;
                        r_flush <= 1'b1;
                        if (w_ertn && !w_int && !w_exc_a && !w_exc_b) begin
                            r_restore_state <= 1'b1;
                            r_flush_pc      <= era_cur;
                        end else begin
                            r_ecode_we    <= 1'b1;
                            r_era_we      <= 1'b1;
                            r_store_state <= 1'b1;
                            r_flush_pc    <= eentry;
                            if (w_int) begin
                                // The interrupt is attributed to the oldest live slot.
                                r_ecode_out <= INT_ECODE;
                                r_era_out   <= a_valid ? a_pc : b_pc;
                            end else if (w_exc_a) begin
                                // Slot B is younger and is squashed.
                                r_ecode_out <= ecode_a;
                                r_era_out   <= a_pc;
                                r_badv_out  <= badv_a;
                                r_badv_we   <= badv_we_a;
                            end else begin
                                r_ecode_out <= ecode_b;
                                r_era_out   <= b_pc;
                                r_badv_out  <= badv_b;
                                r_badv_we   <= badv_we_b;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        if (r_cnt == 4'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ecode_out     = r_ecode_out;
    assign ecode_we      = r_ecode_we;
    assign badv_out      = r_badv_out;
    assign badv_we       = r_badv_we;
    assign era_out       = r_era_out;
    assign era_we        = r_era_we;
    assign store_state   = r_store_state;
    assign restore_state = r_restore_state;
    assign flush         = r_flush;
    assign flush_pc      = r_flush_pc;
    assign busy          = r_busy;

endmodule

// File: tb/tb_csr_exc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csr_exc_sequencer
//
// Directed trap scenarios followed by random traffic. Each clock edge feeds
// a reference model that keeps the number of drain cycles left as a plain
// integer. That model predicts every output, and all outputs are compared
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_csr_exc_sequencer;

    localparam int unsigned DRAIN_CYC = 3;
    localparam logic [6:0]  INT_ECODE = 7'h00;

    logic        clk = 1'b0;
    logic        rstn, stall, a_valid, b_valid;
    logic [31:0] a_pc, b_pc, badv_a, badv_b, eentry, era_cur;
    logic [6:0]  ecode_a, ecode_b;
    logic        ecode_we_a, ecode_we_b, badv_we_a, badv_we_b;
    logic        ertn_b, int_pending, crmd_ie;
    logic [6:0]  ecode_out;
    logic [31:0] badv_out, era_out, flush_pc;
    logic        ecode_we, badv_we, era_we, store_state, restore_state, flush, busy;

    // Reference model state and expected outputs.
    int          m_left;
    logic [6:0]  e_ecode;
    logic [31:0] e_badv, e_era, e_fpc;
    logic        e_ecode_we, e_badv_we, e_era_we, e_store, e_restore, e_flush;

    int tests    = 0;
    int failures = 0;

    csr_exc_sequencer #(.DRAIN_CYC(DRAIN_CYC), .INT_ECODE(INT_ECODE)) dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .a_valid(a_valid), .b_valid(b_valid), .a_pc(a_pc), .b_pc(b_pc),
        .ecode_a(ecode_a), .ecode_b(ecode_b),
        .ecode_we_a(ecode_we_a), .ecode_we_b(ecode_we_b),
        .badv_a(badv_a), .badv_b(badv_b),
        .badv_we_a(badv_we_a), .badv_we_b(badv_we_b),
        .ertn_b(ertn_b), .int_pending(int_pending), .crmd_ie(crmd_ie),
        .eentry(eentry), .era_cur(era_cur),
        .ecode_out(ecode_out), .ecode_we(ecode_we),
        .badv_out(badv_out), .badv_we(badv_we),
        .era_out(era_out), .era_we(era_we),
        .store_state(store_state), .restore_state(restore_state),
        .flush(flush), .flush_pc(flush_pc), .busy(busy)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: at most one trap per unstalled idle cycle,
    // followed by DRAIN_CYC unstalled cycles of deafness.
    task automatic model_edge();
        if (!rstn) begin
            m_left = 0;
            e_ecode = '0; e_badv = '0; e_era = '0; e_fpc = '0;
            e_ecode_we = 0; e_badv_we = 0; e_era_we = 0;
            e_store = 0; e_restore = 0; e_flush = 0;
        end else begin
            e_ecode_we = 0; e_badv_we = 0; e_era_we = 0;
            e_store = 0; e_restore = 0; e_flush = 0;
            if (m_left > 0) begin
                if (!stall) m_left--;
            end else if (!stall) begin
                if (int_pending && crmd_ie && (a_valid || b_valid)) begin
                    e_ecode = INT_ECODE;
                    e_era   = a_valid ? a_pc : b_pc;
                    e_ecode_we = 1; e_era_we = 1; e_store = 1; e_flush = 1;
                    e_fpc = eentry; m_left = DRAIN_CYC;
                end else if (a_valid && ecode_we_a) begin
                    e_ecode = ecode_a; e_era = a_pc; e_badv = badv_a; e_badv_we = badv_we_a;
                    e_ecode_we = 1; e_era_we = 1; e_store = 1; e_flush = 1;
                    e_fpc = eentry; m_left = DRAIN_CYC;
                end else if (b_valid && ecode_we_b) begin
                    e_ecode = ecode_b; e_era = b_pc; e_badv = badv_b; e_badv_we = badv_we_b;
                    e_ecode_we = 1; e_era_we = 1; e_store = 1; e_flush = 1;
                    e_fpc = eentry; m_left = DRAIN_CYC;
                end else if (b_valid && ertn_b) begin
                    e_restore = 1; e_flush = 1; e_fpc = era_cur; m_left = DRAIN_CYC;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("ecode_out", 32'(ecode_out), 32'(e_ecode));
        chk("ecode_we", 32'(ecode_we), 32'(e_ecode_we));
        chk("badv_out", badv_out, e_badv);
        chk("badv_we", 32'(badv_we), 32'(e_badv_we));
        chk("era_out", era_out, e_era);
        chk("era_we", 32'(era_we), 32'(e_era_we));
        chk("store_state", 32'(store_state), 32'(e_store));
        chk("restore_state", 32'(restore_state), 32'(e_restore));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("flush_pc", flush_pc, e_fpc);
        chk("busy", 32'(busy), 32'(m_left > 0));
    endtask

    // Driver: one clock edge, model update, compare after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic quiet();
        stall = 0; a_valid = 0; b_valid = 0; ecode_we_a = 0; ecode_we_b = 0;
        badv_we_a = 0; badv_we_b = 0; ertn_b = 0; int_pending = 0; crmd_ie = 0;
    endtask

    initial begin
        // T1: reset with every input active
        rstn = 0; stall = 0; a_valid = 1; b_valid = 1; a_pc = 32'h1c000100; b_pc = 32'h1c000104;
        ecode_a = 7'h09; ecode_b = 7'h0B; ecode_we_a = 1; ecode_we_b = 1;
        badv_a = 32'hdead0000; badv_b = 32'hbeef0000; badv_we_a = 1; badv_we_b = 1;
        ertn_b = 1; int_pending = 1; crmd_ie = 1; eentry = 32'h1c008000; era_cur = 32'h1c000500;
        step(); step();
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_flush", 32'(flush), 32'd0);
        rstn = 1; quiet(); step();

        // T2: A and B both raise; A wins
        a_valid = 1; b_valid = 1; ecode_we_a = 1; ecode_we_b = 1; badv_we_a = 1;
        ecode_a = 7'h09; a_pc = 32'h1c000100; ecode_b = 7'h0B;
        step();
        chk("t2_ecode", 32'(ecode_out), 32'h09);
        chk("t2_era", era_out, 32'h1c000100);
        chk("t2_fpc", flush_pc, 32'h1c008000);
        chk("t2_busy0", 32'(busy), 32'd1);
        quiet();
        step(); chk("t2_busy1", 32'(busy), 32'd1);
        step(); chk("t2_busy2", 32'(busy), 32'd1);
        step(); chk("t2_busy3", 32'(busy), 32'd0);

        // T3: interrupt beats ERTN
        int_pending = 1; crmd_ie = 1; ertn_b = 1; b_valid = 1; b_pc = 32'h200;
        step();
        chk("t3_ecode", 32'(ecode_out), 32'(INT_ECODE));
        chk("t3_era", era_out, 32'h200);
        chk("t3_restore", 32'(restore_state), 32'd0);
        quiet(); step(); step(); step();

        // T4: ERTN held under stall
        b_valid = 1; ertn_b = 1; stall = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_stall_flush", 32'(flush), 32'd0);
        end
        stall = 0; step();
        chk("t4_restore", 32'(restore_state), 32'd1);
        chk("t4_fpc", flush_pc, 32'h1c000500);
        quiet(); step();
        chk("t4_flush_drop", 32'(flush), 32'd0);
        step(); step();

        // T5: slot A exception presented during drain
        b_valid = 1; ecode_we_b = 1; ecode_b = 7'h0A;
        step();
        quiet(); a_valid = 1; ecode_we_a = 1; ecode_a = 7'h0C;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_ignored", 32'(ecode_we), 32'd0);
        end
        step();
        chk("t5_accept_we", 32'(ecode_we), 32'd1);
        chk("t5_accept_code", 32'(ecode_out), 32'h0C);
        quiet(); step(); step(); step();

        // T6: reset during drain
        a_valid = 1; ecode_we_a = 1; step();
        quiet(); step();
        rstn = 0; step();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pulse", 32'(ecode_we), 32'd0);
        rstn = 1; step();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            rstn        = ($urandom_range(0, 99) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            a_valid     = $urandom_range(0, 1);
            b_valid     = $urandom_range(0, 1);
            a_pc        = $urandom; b_pc = $urandom;
            ecode_a     = 7'($urandom); ecode_b = 7'($urandom);
            ecode_we_a  = ($urandom_range(0, 3) == 0);
            ecode_we_b  = ($urandom_range(0, 3) == 0);
            badv_a      = $urandom; badv_b = $urandom;
            badv_we_a   = $urandom_range(0, 1);
            badv_we_b   = $urandom_range(0, 1);
            ertn_b      = ($urandom_range(0, 2) == 0);
            int_pending = ($urandom_range(0, 4) == 0);
            crmd_ie     = $urandom_range(0, 1);
            eentry      = $urandom; era_cur = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
